// File: rtl/int_inj_pkg.sv
// rtl/int_inj_pkg.sv - shared state encoding, constants and priority helper for int_injector
package int_inj_pkg;

    // Per-channel FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ARMED    = 3'd1;
    localparam state_t ST_PENDING  = 3'd2;
    localparam state_t ST_COOLDOWN = 3'd3;
    localparam state_t ST_DONE     = 3'd4;

    // Default word address whose store acknowledges an interrupt
    localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h0000_7F20;

    // pending_id value when no channel is requesting
    localparam logic [2:0] NO_PENDING = 3'd7;

    // Lowest set bit index of a 6-bit request vector, NO_PENDING if empty
    function automatic logic [2:0] lowest_id(input logic [5:0] v);
        lowest_id = NO_PENDING;
        for (int k = 5; k >= 0; k--) begin
            if (v[k]) lowest_id = 3'(k);
        end
    endfunction

endpackage

// File: rtl/int_inj_channel.sv
// rtl/int_inj_channel.sv - one interrupt channel: FSM, pulse/timeout counter, fire counter (INT_INJECTOR_TIMEOUT_EN adds timeout)
module int_inj_channel
    import int_inj_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int PULSE_LEN = 4
`ifdef INT_INJECTOR_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 1024
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_pulse_mode,
    input  logic             i_pc_hit,
    input  logic             i_ack,
    input  logic [CNT_W-1:0] i_fire_limit,
    output logic             o_irq,
    output logic [CNT_W-1:0] o_fire_count
`ifdef INT_INJECTOR_TIMEOUT_EN
    ,
    output logic             o_timeout_flag
`endif
);

    state_t             r_state;
    logic               r_irq;
    logic [CNT_W-1:0]   r_fire_count;
    logic [31:0]        r_cnt;
    logic               r_from_done;
`ifdef INT_INJECTOR_TIMEOUT_EN
    logic               r_timeout_flag;
`endif

    // Channel state machine; r_cnt times the pulse (and the ack timeout when enabled)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_ARMED;
            r_irq        <= 1'b0;
            r_fire_count <= '0;
            r_cnt        <= '0;
            r_from_done  <= 1'b0;
`ifdef INT_INJECTOR_TIMEOUT_EN
            r_timeout_flag <= 1'b0;
`endif
        end else if (!i_enable) begin
            // Disable wins over everything; fire_count is held. Remember
            // whether we were DONE so the next enable edge restarts the count.
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
            if (r_state == ST_DONE) r_from_done <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_ARMED;
                    if (r_from_done) begin
                        r_fire_count <= '0;
                        r_from_done  <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (i_pc_hit) begin
                        r_state <= ST_PENDING;
                        r_irq   <= 1'b1;
                        r_cnt   <= '0;
                        if (r_fire_count != {CNT_W{1'b1}}) r_fire_count <= r_fire_count + 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (i_pulse_mode) begin
                        if (r_cnt == 32'(PULSE_LEN - 1)) begin
                            r_irq   <= 1'b0;
                            r_state <= ST_COOLDOWN;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end else if (i_ack) begin
                        r_irq   <= 1'b0;
                        r_state <= ST_COOLDOWN;
                    end
`ifdef INT_INJECTOR_TIMEOUT_EN
                    else if (r_cnt == 32'(TIMEOUT - 1)) begin
                        r_irq          <= 1'b0;
                        r_state        <= ST_COOLDOWN;
                        r_timeout_flag <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
`endif
                end
                ST_COOLDOWN: begin
                    // A PC stalled on the target must not re-fire
                    if (!i_pc_hit) begin
                        if ((i_fire_limit != '0) && (r_fire_count == i_fire_limit))
                            r_state <= ST_DONE;
                        else
                            r_state <= ST_ARMED;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                end
            endcase
        end
    end

    assign o_irq        = r_irq;
    assign o_fire_count = r_fire_count;
`ifdef INT_INJECTOR_TIMEOUT_EN
    assign o_timeout_flag = r_timeout_flag;
`endif

endmodule

// File: rtl/int_injector.sv
// rtl/int_injector.sv - multi-channel PC-triggered interrupt injector top (INT_INJECTOR_TIMEOUT_EN adds ack timeout)
module int_injector
    import int_inj_pkg::*;
#(
    parameter int          CHANNELS  = 4,
    parameter logic [31:0] ACK_ADDR  = ACK_ADDR_DEFAULT,
    parameter int          CNT_W     = 8,
    parameter int          PULSE_LEN = 4
`ifdef INT_INJECTOR_TIMEOUT_EN
    ,
    parameter int          TIMEOUT   = 1024
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               macroscopic_pc,
    input  logic [31:0]               m_int_addr,
    input  logic [3:0]                m_int_byteen,
    input  logic [CHANNELS-1:0]       ch_enable,
    input  logic [CHANNELS-1:0]       ch_pulse_mode,
    input  logic [CHANNELS*32-1:0]    target_pc,
    input  logic [CHANNELS*CNT_W-1:0] fire_limit,
    output logic [CHANNELS-1:0]       irq,
    output logic                      interrupt,
    output logic [CHANNELS*CNT_W-1:0] fire_count,
    output logic [2:0]                pending_id
`ifdef INT_INJECTOR_TIMEOUT_EN
    ,
    output logic [CHANNELS-1:0]       timeout_flag
`endif
);

    logic                w_ack;
    logic [CHANNELS-1:0] w_irq;
    logic [CHANNELS-1:0] w_lvl_pend;
    logic [CHANNELS-1:0] w_ack_onehot;
    logic [5:0]          w_irq_ext;

    // Ack decode ignores the byte offset within the word
    assign w_ack = (|m_int_byteen) &&
                   ((m_int_addr & ~32'h3) == (ACK_ADDR & ~32'h3));

    // Acks are serialized: only the lowest-index level-mode requester,
    // judged on the registered irq, sees this ack
    assign w_lvl_pend   = w_irq & ~ch_pulse_mode;
    assign w_ack_onehot = w_lvl_pend & (-w_lvl_pend);

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            logic w_pc_hit;
            assign w_pc_hit = ((macroscopic_pc & ~32'h3) == (target_pc[g*32 +: 32] & ~32'h3));

            int_inj_channel #(
                .CNT_W     (CNT_W),
                .PULSE_LEN (PULSE_LEN)
`ifdef INT_INJECTOR_TIMEOUT_EN
                ,
                .TIMEOUT   (TIMEOUT)
`endif
            ) u_ch (
                .clk          (clk),
                .reset        (reset),
                .i_enable     (ch_enable[g]),
                .i_pulse_mode (ch_pulse_mode[g]),
                .i_pc_hit     (w_pc_hit),
                .i_ack        (w_ack & w_ack_onehot[g]),
                .i_fire_limit (fire_limit[g*CNT_W +: CNT_W]),
                .o_irq        (w_irq[g]),
                .o_fire_count (fire_count[g*CNT_W +: CNT_W])
`ifdef INT_INJECTOR_TIMEOUT_EN
                ,
                .o_timeout_flag (timeout_flag[g])
`endif
            );
        end
    endgenerate

    // Widen irq to the six HWInt positions for the priority encoder
    always_comb begin
        w_irq_ext = '0;
        w_irq_ext[CHANNELS-1:0] = w_irq;
    end

    assign irq        = w_irq;
    assign interrupt  = |w_irq;
    assign pending_id = lowest_id(w_irq_ext);

endmodule

// File: tb/tb_int_injector.sv
// tb/tb_int_injector.sv - directed scoreboard bench for int_injector
module tb_int_injector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] macroscopic_pc = 32'h1000;
    logic [31:0] m_int_addr = 32'h0;
    logic [3:0]  m_int_byteen = 4'h0;
    logic [3:0]  ch_enable = 4'h0;
    logic [3:0]  ch_pulse_mode = 4'h0;
    logic [127:0] target_pc = '0;
    logic [31:0] fire_limit = '0;
    logic [3:0]  irq;
    logic        interrupt;
    logic [31:0] fire_count;
    logic [2:0]  pending_id;
`ifdef INT_INJECTOR_TIMEOUT_EN
    logic [3:0]  timeout_flag;
`endif

    always #5 clk = ~clk;

    int_injector #(
        .CHANNELS  (4),
        .ACK_ADDR  (32'h0000_7F20),
        .CNT_W     (8),
        .PULSE_LEN (4)
`ifdef INT_INJECTOR_TIMEOUT_EN
        ,
        .TIMEOUT   (8)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .macroscopic_pc (macroscopic_pc),
        .m_int_addr     (m_int_addr),
        .m_int_byteen   (m_int_byteen),
        .ch_enable      (ch_enable),
        .ch_pulse_mode  (ch_pulse_mode),
        .target_pc      (target_pc),
        .fire_limit     (fire_limit),
        .irq            (irq),
        .interrupt      (interrupt),
        .fire_count     (fire_count),
        .pending_id     (pending_id)
`ifdef INT_INJECTOR_TIMEOUT_EN
        ,
        .timeout_flag   (timeout_flag)
`endif
    );

    typedef struct {
        logic [3:0]  irq;
        logic [31:0] fc;
        logic [3:0]  tf;
        string       name;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_miss = 0;

    // Configuration applied at the next stimulus cycle
    logic        n_reset = 1'b1;
    logic [3:0]  n_en = 4'h0;
    logic [7:0]  e_fc[4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [3:0]  e_tf = 4'h0;

    function automatic logic [2:0] exp_pid(input logic [3:0] v);
        if (v[0]) return 3'd0;
        if (v[1]) return 3'd1;
        if (v[2]) return 3'd2;
        if (v[3]) return 3'd3;
        return 3'd7;
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be after that edge
    task automatic cyc(input string nm, input logic [31:0] pc, input logic [31:0] aa,
                       input logic [3:0] be, input logic [3:0] eirq);
        exp_t e;
        @(negedge clk);
        reset          = n_reset;
        ch_enable      = n_en;
        macroscopic_pc = pc;
        m_int_addr     = aa;
        m_int_byteen   = be;
        e.irq  = eirq;
        e.fc   = {e_fc[3], e_fc[2], e_fc[1], e_fc[0]};
        e.tf   = e_tf;
        e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: compare the registered outputs just after each edge that has an expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (irq !== e.irq) begin
                n_miss++;
                $display("FAIL %s irq got=%b exp=%b", e.name, irq, e.irq);
            end
            if (interrupt !== (|e.irq)) begin
                n_miss++;
                $display("FAIL %s interrupt got=%b exp=%b", e.name, interrupt, |e.irq);
            end
            if (pending_id !== exp_pid(e.irq)) begin
                n_miss++;
                $display("FAIL %s pending_id got=%0d exp=%0d", e.name, pending_id, exp_pid(e.irq));
            end
            if (fire_count !== e.fc) begin
                n_miss++;
                $display("FAIL %s fire_count got=%h exp=%h", e.name, fire_count, e.fc);
            end
`ifdef INT_INJECTOR_TIMEOUT_EN
            if (timeout_flag !== e.tf) begin
                n_miss++;
                $display("FAIL %s timeout_flag got=%b exp=%b", e.name, timeout_flag, e.tf);
            end
`endif
        end
    end

    localparam logic [31:0] IDLE_PC = 32'h1000;
    localparam logic [31:0] ACK     = 32'h7F20;

    initial begin
        target_pc     = {32'h3040, 32'h3020, 32'h3020, 32'h3010};
        fire_limit    = {8'd0, 8'd0, 8'd0, 8'd1};
        ch_pulse_mode = 4'b1000;

        // Reset state
        n_reset = 1'b1;
        cyc("reset0", IDLE_PC, 0, 4'h0, 4'b0000);
        n_en = 4'b0001;
        cyc("reset1", IDLE_PC, 0, 4'h0, 4'b0000);
        n_reset = 1'b0;

        // Single level fire, limit 1
        cyc("l_armed", IDLE_PC, 0, 4'h0, 4'b0000);
        e_fc[0] = 8'd1;
        cyc("l_fire",  32'h3010, 0, 4'h0, 4'b0001);
        cyc("l_hold",  32'h3014, 0, 4'h0, 4'b0001);
        cyc("l_ack",   32'h3014, ACK, 4'hF, 4'b0000);
        cyc("l_cool",  32'h3018, 0, 4'h0, 4'b0000);
        cyc("l_done",  32'h3010, 0, 4'h0, 4'b0000);
        cyc("l_idle",  IDLE_PC, 0, 4'h0, 4'b0000);

        // Dual pending serialization
        n_en = 4'b0110;
        cyc("d_arm",   IDLE_PC, 0, 4'h0, 4'b0000);
        e_fc[1] = 8'd1; e_fc[2] = 8'd1;
        cyc("d_fire",  32'h3020, 0, 4'h0, 4'b0110);
        cyc("d_hold",  IDLE_PC, 0, 4'h0, 4'b0110);
        cyc("d_ack1",  IDLE_PC, ACK, 4'hF, 4'b0100);
        cyc("d_hold2", IDLE_PC, 0, 4'h0, 4'b0100);
        cyc("d_ack2",  IDLE_PC, ACK, 4'hF, 4'b0000);
        // ch1 re-armed, ch2 still cooling on the hit; stray ack with nothing pending
        e_fc[1] = 8'd2;
        cyc("d_refire", 32'h3020, ACK, 4'hF, 4'b0010);
        cyc("d_c2arm",  IDLE_PC, 0, 4'h0, 4'b0010);
        // ack retires ch1 while ch2 fires in the same cycle
        e_fc[2] = 8'd2;
        cyc("d_simul",  32'h3020, ACK, 4'hF, 4'b0100);
        cyc("d_ack3",   IDLE_PC, ACK, 4'hF, 4'b0000);

        // Pulse mode on ch3, ack ignored
        n_en = 4'b1000;
        cyc("p_arm",   IDLE_PC, 0, 4'h0, 4'b0000);
        e_fc[3] = 8'd1;
        cyc("p_fire",  32'h3040, 0, 4'h0, 4'b1000);
        cyc("p_ack",   IDLE_PC, ACK, 4'hF, 4'b1000);
        cyc("p_hi3",   IDLE_PC, 0, 4'h0, 4'b1000);
        cyc("p_hi4",   IDLE_PC, 0, 4'h0, 4'b1000);
        cyc("p_drop",  IDLE_PC, 0, 4'h0, 4'b0000);
        cyc("p_low",   IDLE_PC, 0, 4'h0, 4'b0000);

        // Re-enable ch0 from DONE, unlimited, stalled PC
        n_en = 4'b0001;
        fire_limit[7:0] = 8'd0;
        e_fc[0] = 8'd0;
        cyc("s_reen",  IDLE_PC, 0, 4'h0, 4'b0000);
        e_fc[0] = 8'd1;
        cyc("s_fire",  32'h3010, 0, 4'h0, 4'b0001);
        cyc("s_ack",   32'h3010, ACK, 4'hF, 4'b0000);
        for (int i = 0; i < 8; i++) cyc("s_stall", 32'h3010, 0, 4'h0, 4'b0000);
        cyc("s_leave", IDLE_PC, 0, 4'h0, 4'b0000);

        // Byte-offset match and byte-offset ack
        e_fc[0] = 8'd2;
        cyc("b_off",     32'h3012, 0, 4'h0, 4'b0001);
        cyc("b_ack",     IDLE_PC, 32'h7F22, 4'h1, 4'b0000);
        cyc("b_rearm",   IDLE_PC, 0, 4'h0, 4'b0000);
        e_fc[0] = 8'd3;
        cyc("b_fire",    32'h3010, 0, 4'h0, 4'b0001);
        cyc("b_nobe",    IDLE_PC, ACK, 4'h0, 4'b0001);
        cyc("b_badaddr", IDLE_PC, 32'h7F24, 4'hF, 4'b0001);

        // Reset while pending
        n_reset = 1'b1;
        e_fc = '{8'd0, 8'd0, 8'd0, 8'd0};
        cyc("r_mid",   IDLE_PC, 0, 4'h0, 4'b0000);
        n_reset = 1'b0;
        cyc("r_after", IDLE_PC, 0, 4'h0, 4'b0000);

`ifdef INT_INJECTOR_TIMEOUT_EN
        // Unacked level request times out after 8 cycles
        e_fc[0] = 8'd1;
        cyc("t_fire", 32'h3010, 0, 4'h0, 4'b0001);
        for (int i = 0; i < 7; i++) cyc("t_wait", IDLE_PC, 0, 4'h0, 4'b0001);
        e_tf = 4'b0001;
        cyc("t_drop",   IDLE_PC, 0, 4'h0, 4'b0000);
        cyc("t_sticky", IDLE_PC, 0, 4'h0, 4'b0000);
`endif

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain queue_left=%0d exp=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t exp=finish", $time);
        $fatal(1);
    end

endmodule
